exe_div_ctrl: RTL and testbench
===============================

// Module: exe_div_ctrl
// PURPOSE
//  Multi-cycle divide sequencer for the EXE stage: DIV.W/MOD.W/DIV.WU/MOD.WU.
//  Owns a radix-2 restoring divider. Holds EXE via div_stall (EXE stall input) until the result is ready.
//  Its result is muxed onto es_rf_wdata in place of the ALU result for divide ops.
// PARAMETERS
//  XLEN   32                 operand/result width
//  CNT_W  $clog2(XLEN)       iteration counter width
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high reset
//  es_valid     in   1     EXE holds a valid instruction
//  div_req      in   1     EXE instruction is a divide/mod op
//  div_op       in   2     [0]=1 mod (remainder), 0 div (quotient); [1]=1 unsigned
//  div_src1     in   XLEN  dividend (post-forwarding)
//  div_src2     in   XLEN  divisor (post-forwarding)
//  ms_allow_in  in   1     MEM accepts this cycle (EXE->MEM transfer when !div_stall)
//  div_stall    out  1     to EXE stall; EXE es_ready_go = !div_stall
//  div_result   out  XLEN  quotient or remainder per div_op; valid in DONE
//  div_busy     out  1     state != IDLE
// BEHAVIOUR
//  States: IDLE, BUSY, DONE. Reset -> IDLE, cnt=0, div_result=0, div_busy=0.
//  div_stall = es_valid & div_req & (state!=DONE)  (combinational; 0 in reset cycle).
//  IDLE: es_valid&div_req -> latch |src1|,|src2|, signs, op; rem_acc=0; cnt=0; -> BUSY.
//  BUSY: one quotient bit/cycle: rem={rem,dvd[MSB]}; if rem>=dvs rem-=dvs, q bit=1.
//    cnt==XLEN-1 -> DONE, with sign fix-up applied on that edge.
//  Latency: request in IDLE at cycle N -> BUSY N+1..N+XLEN -> DONE at N+XLEN+1, stall low.
//  DONE: div_result stable; ms_allow_in -> IDLE (instruction leaves EXE). Else hold.
//  Back-to-back divides: second op is seen in IDLE the cycle after the first leaves; no lost cycle beyond that.
//  Cancel: es_valid or div_req low while in BUSY/DONE -> IDLE next cycle; no result issued.
//  Sign rules (signed ops): magnitudes divided unsigned.
//    Quotient negated iff sign(src1)!=sign(src2). Remainder takes sign(src1).
//  Divide by zero: quotient = all ones (unsigned view, pre sign-fix skipped); remainder = src1. Takes full latency.
//  Overflow 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0 (natural two's-complement result).
//  Unsigned ops: no sign fix-up, operands used raw.
//  Reset at any state: -> IDLE next edge; div_stall deasserted while in reset.
// CONFIGURATION
//  DIV_FAST_PATH_EN defined: in IDLE, if |src2|==0 or |src2|>|src1|,
//    go straight to DONE at N+1 (q=0 or all-ones/zero-div rules; r=src1).
//  DIV_FAST_PATH_EN undefined: every divide takes full XLEN-iteration latency.
//  Results are bit-identical either way.
// STRUCTURE
//  Package exe_div_pkg: state encoding (IDLE/BUSY/DONE), div_op bit positions, XLEN default.
//  Sub-module div_step: combinational one-bit restoring step (rem_in, dvd_msb, dvs -> rem_out, q_bit).
//  Top: FSM, counter, operand/sign regs, fix-up.
// TESTING
//  DIV.W 100/7 -> stall 33 cycles, div_result=14; MOD.W 100/7 -> 2.
//  DIV.W -7/2 -> 0xFFFFFFFD; MOD.W -7/2 -> 0xFFFFFFFF; DIV.WU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
//  DIV.W 5/0 -> 0xFFFFFFFF; MOD.W 5/0 -> 5; DIV.W 0x80000000/0xFFFFFFFF -> 0x80000000, MOD -> 0.
//  Hold ms_allow_in=0 for 5 cycles in DONE -> result and state held, stall 0; then release -> IDLE.
//  Two back-to-back DIV.W (20/3, 9/4) -> 6 then 2; second starts the cycle after first transfers.
//  Assert reset at cnt=10 -> next cycle IDLE, div_stall=0, div_busy=0.
//  Drop es_valid at cnt=5 -> IDLE next cycle.
//  With DIV_FAST_PATH_EN: 3/7 -> q=0, r=3 at N+1.

Source files
------------

// File: rtl/exe_div_pkg.sv
// Shared definitions for the EXE-stage divide sequencer:
// FSM state encoding, div_op bit positions and default width.
package exe_div_pkg;
  localparam int DIV_XLEN = 32;
  localparam int OP_MOD   = 0;
  localparam int OP_UNS   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/exe_div_ctrl_div_step.sv
// One combinational radix-2 restoring divide step.
// Ports: rem_in/dvd_msb/dvs in; rem_out/q_bit out.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         dvd_msb,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0] sh;

  assign sh    = {rem_in, dvd_msb};
  assign q_bit = sh >= {1'b0, dvs};
  // When the subtract happens the result is < dvs, so
  // modulo-2^W arithmetic on the low bits is exact.
  assign rem_out = q_bit ? (sh[W-1:0] - dvs) : sh[W-1:0];
endmodule

// File: rtl/exe_div_ctrl.sv
// Multi-cycle DIV.W/MOD.W/DIV.WU/MOD.WU sequencer for EXE.
// Ports: clk, reset, es_valid, div_req, div_op, div_src1,
//   div_src2, ms_allow_in in; div_stall, div_result,
//   div_busy out. Option macro: DIV_FAST_PATH_EN.
module exe_div_ctrl
  import exe_div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            es_valid,
  input  logic            div_req,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  input  logic            ms_allow_in,
  output logic            div_stall,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy
);
  div_state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvd;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  rem;
  logic             neg_q;
  logic             neg_r;
  logic             is_mod;

  logic            req;
  logic            sgn;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            fast;
  logic            last;
  logic [XLEN-1:0] rem_out;
  logic            q_bit;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign req  = es_valid & div_req;
  assign sgn  = ~div_op[OP_UNS];
  assign abs1 = (sgn & div_src1[XLEN-1]) ? -div_src1 : div_src1;
  assign abs2 = (sgn & div_src2[XLEN-1]) ? -div_src2 : div_src2;
  assign last = cnt == CNT_W'(XLEN-1);

`ifdef DIV_FAST_PATH_EN
  // Quotient is trivially 0 (or all ones on zero divisor).
  assign fast = (abs2 == '0) | (abs2 > abs1);
`else
  assign fast = 1'b0;
`endif

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem),
    .dvd_msb (dvd[XLEN-1]),
    .dvs     (dvs),
    .rem_out (rem_out),
    .q_bit   (q_bit)
  );

  // Zero divisor yields all ones unsigned; no negation then.
  assign q_fin = {dvd[XLEN-2:0], q_bit};
  assign q_fix = (neg_q & (dvs != '0)) ? -q_fin : q_fin;
  assign r_fix = neg_r ? -rem_out : rem_out;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (req) state_n = fast ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (!req)      state_n = S_IDLE;
        else if (last) state_n = S_DONE;
      end
      S_DONE: if (!req || ms_allow_in) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_mod     <= 1'b0;
      div_result <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req) begin
        dvd    <= abs1;
        dvs    <= abs2;
        rem    <= '0;
        cnt    <= '0;
        neg_q  <= sgn & (div_src1[XLEN-1] ^ div_src2[XLEN-1]);
        neg_r  <= sgn & div_src1[XLEN-1];
        is_mod <= div_op[OP_MOD];
        if (fast)
          div_result <= div_op[OP_MOD] ? div_src1 :
                        ((abs2 == '0) ? '1 : '0);
      end else if (state == S_BUSY) begin
        dvd <= q_fin;
        rem <= rem_out;
        cnt <= cnt + CNT_W'(1);
        if (last && req)
          div_result <= is_mod ? r_fix : q_fix;
      end
    end
  end

  assign div_stall = req & (state != S_DONE) & ~reset;
  assign div_busy  = state != S_IDLE;
endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl: random divides
// against an arithmetic reference model, plus directed cases.
module tb_exe_div_ctrl;
  localparam logic [1:0] DIVW  = 2'b00;
  localparam logic [1:0] MODW  = 2'b01;
  localparam logic [1:0] DIVWU = 2'b10;
  localparam logic [1:0] MODWU = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_valid;
  logic        div_req;
  logic [1:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        ms_allow_in;
  logic        div_stall;
  logic [31:0] div_result;
  logic        div_busy;

  exe_div_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .es_valid    (es_valid),
    .div_req     (div_req),
    .div_op      (div_op),
    .div_src1    (div_src1),
    .div_src2    (div_src2),
    .ms_allow_in (ms_allow_in),
    .div_stall   (div_stall),
    .div_result  (div_result),
    .div_busy    (div_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit active = 0;
  int start_cyc;
  int done_cyc;
  logic [31:0] exp_result;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 0) return op[0] ? a : 32'hFFFF_FFFF;
    if (op[1]) return op[0] ? a % b : a / b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[0] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int lat(input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
    logic [31:0] ua, ub;
    ua = (!op[1] && a[31]) ? -a : a;
    ub = (!op[1] && b[31]) ? -b : b;
    if (ub == 0 || ub > ua) return 1;
`endif
    return 33;
  endfunction

  always @(negedge clk) begin
    if (active) begin
      chk("stall", 32'(div_stall),
          32'(es_valid && div_req && cyc < done_cyc));
      chk("busy", 32'(div_busy), 32'(cyc > start_cyc));
      if (cyc >= done_cyc) chk("result", div_result, exp_result);
    end
  end

  task automatic start_div(input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b);
    es_valid   = 1;
    div_req    = 1;
    div_op     = op;
    div_src1   = a;
    div_src2   = b;
    ms_allow_in = 0;
    exp_result = model(op, a, b);
    start_cyc  = cyc;
    done_cyc   = cyc + lat(op, a, b);
    active     = 1;
  endtask

  task automatic run_div(input logic [1:0] op, input logic [31:0] a,
      input logic [31:0] b, input int hold);
    start_div(op, a, b);
    repeat (done_cyc - start_cyc + hold) @(posedge clk);
    #1 ms_allow_in = 1;
    @(posedge clk);
    #1;
    ms_allow_in = 0;
    active   = 0;
    es_valid = 0;
    div_req  = 0;
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, 32'(div_busy), 0);
    chk({nm, "_stall"}, 32'(div_stall), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; es_valid = 1; div_req = 1; div_op = DIVW;
    div_src1 = 100; div_src2 = 7; ms_allow_in = 0;
    @(negedge clk);
    chk("rst_stall", 32'(div_stall), 0);
    chk("rst_busy", 32'(div_busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0; es_valid = 0; div_req = 0;
    @(negedge clk);
    chk("rst_result", div_result, 0);
    chk("rst_busy2", 32'(div_busy), 0);
    @(posedge clk);
    #1;

    chk("m_div", model(DIVW, 100, 7), 14);
    chk("m_mod", model(MODW, 100, 7), 2);
    chk("m_neg_div", model(DIVW, -7, 2), 32'hFFFF_FFFD);
    chk("m_neg_mod", model(MODW, -7, 2), 32'hFFFF_FFFF);
    chk("m_divu", model(DIVWU, 32'hFFFF_FFF9, 2), 32'h7FFF_FFFC);
    chk("m_dz", model(DIVW, 5, 0), 32'hFFFF_FFFF);
    chk("m_mz", model(MODW, 5, 0), 5);
    chk("m_ovf", model(DIVW, 32'h8000_0000, 32'hFFFF_FFFF),
        32'h8000_0000);
    chk("m_ovfr", model(MODW, 32'h8000_0000, 32'hFFFF_FFFF), 0);
    chk("m_lat", lat(DIVW, 100, 7), 33);
`ifdef DIV_FAST_PATH_EN
    chk("m_fast_lat", lat(DIVW, 3, 7), 1);
`else
    chk("m_slow_lat", lat(DIVW, 3, 7), 33);
`endif

    run_div(DIVW, 100, 7, 0);
    run_div(MODW, 100, 7, 0);
    run_div(DIVW, -7, 2, 1);
    run_div(MODW, -7, 2, 0);
    run_div(DIVWU, 32'hFFFF_FFF9, 2, 0);
    run_div(DIVW, 5, 0, 0);
    run_div(MODW, 5, 0, 0);
    run_div(DIVW, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(MODW, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle_check("hold_pre");
    run_div(DIVW, 100, 7, 5);
    idle_check("hold_post");
    run_div(DIVW, 20, 3, 0);
    run_div(DIVW, 9, 4, 0);
    run_div(DIVW, 3, 7, 0);
    run_div(MODW, 3, 7, 0);
    idle_check("b2b");

    start_div(DIVW, 1000, 3);
    repeat (6) @(posedge clk);
    #1 es_valid = 0; active = 0;
    @(negedge clk);
    chk("cancel_stall", 32'(div_stall), 0);
    chk("cancel_busy_now", 32'(div_busy), 1);
    @(posedge clk);
    #1 div_req = 0;
    idle_check("cancel");

    start_div(DIVW, 12345, 7);
    repeat (11) @(posedge clk);
    #1 reset = 1; active = 0;
    @(negedge clk);
    chk("rstmid_stall", 32'(div_stall), 0);
    @(posedge clk);
    #1 reset = 0; es_valid = 0; div_req = 0;
    @(negedge clk);
    chk("rstmid_busy", 32'(div_busy), 0);
    chk("rstmid_stall2", 32'(div_stall), 0);
    chk("rstmid_result", div_result, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: ;
        4: b = b >> $urandom_range(0, 31);
        default: a = a >> $urandom_range(16, 31);
      endcase
      run_div(op, a, b, $urandom_range(0, 3));
    end
    idle_check("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
